// File: rtl/otter_axi_mem_device_if.sv
// axi_rw: AXI4-Lite style read/write bus without a B channel or resp codes.
// A write completes on the W handshake. The master drives requests; the
// device (alias slave) modport is the responder side.
interface axi_rw;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid,
        input  arready, rdata, rvalid, awready, wready
    );

    modport device (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid,
        output arready, rdata, rvalid, awready, wready
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid,
        output arready, rdata, rvalid, awready, wready
    );
endinterface

// File: rtl/otter_axi_mem_device.sv
// otter_axi_mem_device: word-organised synchronous RAM responding on the
// axi_rw device modport, with WAIT_CYCLES stall cycles before rvalid/wready.
// Reads take priority over writes when both address channels are valid.
// Optional build macro AXI_MEM_BOUNDS_EN adds a sticky err output and makes
// out-of-range accesses read 32'hDEAD_BEEF and drop writes instead of aliasing.
module otter_axi_mem_device #(
  parameter int WORD_ADDR_BITS = 12,
  parameter int WAIT_CYCLES    = 0,
  parameter     INIT_FILE      = ""
) (
  input  logic   clk,
  input  logic   rst,
  axi_rw.device  bus
`ifdef AXI_MEM_BOUNDS_EN
  ,
  output logic   err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RESP,
    W_WAIT,
    W_DATA
  } state_t;

  localparam int         DEPTH     = 2 ** WORD_ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  logic [31:0]               mem [DEPTH];
  state_t                    state;
  state_t                    state_nx;
  logic [3:0]                cnt;
  logic [3:0]                cnt_nx;
  logic [31:0]               rdata_q;
  logic [WORD_ADDR_BITS-1:0] ar_index;
  logic [WORD_ADDR_BITS-1:0] aw_index;
  logic [WORD_ADDR_BITS-1:0] w_index;
  logic                      ar_hs;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      rd_oob;
  logic                      w_block;

  assign ar_index = bus.araddr[WORD_ADDR_BITS+1:2];
  assign aw_index = bus.awaddr[WORD_ADDR_BITS+1:2];

  assign ar_hs = (state == IDLE) && bus.arvalid;
  assign aw_hs = (state == IDLE) && bus.awvalid && !bus.arvalid;
  assign w_hs  = (state == W_DATA) && bus.wvalid;

  assign bus.arready = (state == IDLE);
  assign bus.awready = (state == IDLE) && !bus.arvalid;
  assign bus.rvalid  = (state == R_RESP);
  assign bus.wready  = (state == W_DATA);
  assign bus.rdata   = rdata_q;

`ifdef AXI_MEM_BOUNDS_EN
  logic ar_oob;
  logic aw_oob;
  logic w_oob_q;
  logic unused_addr_bits;

  assign ar_oob           = |bus.araddr[31:WORD_ADDR_BITS+2];
  assign aw_oob           = |bus.awaddr[31:WORD_ADDR_BITS+2];
  assign rd_oob           = ar_oob;
  assign w_block          = w_oob_q;
  assign unused_addr_bits = ^{bus.araddr[1:0], bus.awaddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      w_oob_q <= 1'b0;
    end else if (aw_hs) begin
      w_oob_q <= aw_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((ar_hs && ar_oob) || (aw_hs && aw_oob)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_addr_bits;

  assign rd_oob           = 1'b0;
  assign w_block          = 1'b0;
  assign unused_addr_bits = ^{bus.araddr[31:WORD_ADDR_BITS+2], bus.araddr[1:0],
                              bus.awaddr[31:WORD_ADDR_BITS+2], bus.awaddr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Counter loaded with WAIT_CYCLES-1 so the wait state spans WAIT_CYCLES cycles
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = R_RESP;
          end else begin
            state_nx = R_WAIT;
            cnt_nx   = WAIT_INIT;
          end
        end else if (aw_hs) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = W_DATA;
          end else begin
            state_nx = W_WAIT;
            cnt_nx   = WAIT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = R_RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          state_nx = IDLE;
        end
      end
      W_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = W_DATA;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      W_DATA: begin
        if (bus.wvalid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_index <= aw_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= rd_oob ? 32'hDEAD_BEEF : mem[ar_index];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs && !w_block) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[w_index][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_axi_mem_device.sv
// Directed bench for otter_axi_mem_device: one instance with no wait states,
// one with three; shared stimulus variables steered to the selected instance.
module tb_otter_axi_mem_device;

    localparam int WB = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] araddr = '0;
    logic [31:0] awaddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0;
    logic        awvalid = 1'b0;
    logic        wvalid = 1'b0;
    logic        rready = 1'b0;

    logic        arready_s, awready_s, rvalid_s, wready_s;
    logic [31:0] rdata_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_rw bus0 ();
    axi_rw bus3 ();

`ifdef AXI_MEM_BOUNDS_EN
    logic err0, err3;
`endif

    assign bus0.araddr  = araddr;
    assign bus0.awaddr  = awaddr;
    assign bus0.wdata   = wdata;
    assign bus0.wstrb   = wstrb;
    assign bus0.arvalid = arvalid & ~sel;
    assign bus0.awvalid = awvalid & ~sel;
    assign bus0.wvalid  = wvalid & ~sel;
    assign bus0.rready  = rready & ~sel;

    assign bus3.araddr  = araddr;
    assign bus3.awaddr  = awaddr;
    assign bus3.wdata   = wdata;
    assign bus3.wstrb   = wstrb;
    assign bus3.arvalid = arvalid & sel;
    assign bus3.awvalid = awvalid & sel;
    assign bus3.wvalid  = wvalid & sel;
    assign bus3.rready  = rready & sel;

    assign arready_s = sel ? bus3.arready : bus0.arready;
    assign awready_s = sel ? bus3.awready : bus0.awready;
    assign rvalid_s  = sel ? bus3.rvalid  : bus0.rvalid;
    assign wready_s  = sel ? bus3.wready  : bus0.wready;
    assign rdata_s   = sel ? bus3.rdata   : bus0.rdata;

    otter_axi_mem_device #(
        .WORD_ADDR_BITS (WB),
        .WAIT_CYCLES    (0),
        .INIT_FILE      ("")
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef AXI_MEM_BOUNDS_EN
        ,
        .err (err0)
`endif
    );

    otter_axi_mem_device #(
        .WORD_ADDR_BITS (WB),
        .WAIT_CYCLES    (3),
        .INIT_FILE      ("")
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
`ifdef AXI_MEM_BOUNDS_EN
        ,
        .err (err3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic do_write(input logic s, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, input int exp_lat, input string tag);
        int k;
        sel = s;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = st; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!awready_s && k < 50) begin @(negedge clk); k++; end
        if (!awready_s) begin
            timeout({tag, "_aw"});
            @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        chk({tag, "_wready_in_aw_cycle"}, wready_s, 0);
        @(posedge clk); #1; awvalid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!wready_s && k < 50);
        chk({tag, "_wready_latency"}, k, exp_lat);
        @(posedge clk); #1; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic s, input logic [31:0] a, input int hold,
                           input int exp_lat, input logic [31:0] exp_d, input string tag);
        int k;
        sel = s;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        k = 0;
        @(negedge clk);
        while (!arready_s && k < 50) begin @(negedge clk); k++; end
        if (!arready_s) begin
            timeout({tag, "_ar"});
            @(posedge clk); #1; arvalid = 1'b0; rready = 1'b0;
            return;
        end
        chk({tag, "_rvalid_in_ar_cycle"}, rvalid_s, 0);
        @(posedge clk); #1; arvalid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rvalid_s && k < 50);
        chk({tag, "_rvalid_latency"}, k, exp_lat);
        chk({tag, "_rdata"}, rdata_s, exp_d);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk($sformatf("%s_hold%0d_rvalid", tag, h), rvalid_s, 1);
                chk($sformatf("%s_hold%0d_rdata", tag, h), rdata_s, exp_d);
            end
            @(posedge clk); #1; rready = 1'b1;
        end
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid_drop"}, rvalid_s, 0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int k;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1234_5678};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b1111, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_EE00, 4'b0010, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'hAABB_EEDD};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'hAABB_EEDD};
        vecs[7]  = '{1'b1, 32'h0000_0024, 32'h1122_3344, 4'b1111, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0024, 32'h00AA_00BB, 4'b0101, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0027, 32'h0,         4'b0000, 32'h11AA_33BB};
        vecs[10] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'b1111, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dut0_rvalid", bus0.rvalid, 0);
        chk("rst_dut0_wready", bus0.wready, 0);
        chk("rst_dut0_rdata", bus0.rdata, 32'h0);
        chk("rst_dut0_arready", bus0.arready, 1);
        chk("rst_dut3_rvalid", bus3.rvalid, 0);
        chk("rst_dut3_wready", bus3.wready, 0);
        chk("rst_dut3_rdata", bus3.rdata, 32'h0);
`ifdef AXI_MEM_BOUNDS_EN
        chk("rst_err0", err0, 0);
        chk("rst_err3", err3, 0);
`endif

        // Table-driven transactions, no wait states
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr)
                do_write(1'b0, vecs[i].addr, vecs[i].data, vecs[i].strb, 1, $sformatf("v%0d_wr", i));
            else
                do_read(1'b0, vecs[i].addr, 0, 1, vecs[i].exp, $sformatf("v%0d_rd", i));
        end
        do_read(1'b0, 32'h0000_3FFC, 0, 1, 32'hCAFE_F00D, "last_word_rd");

        // Simultaneous AR and AW: read first, AW in the following IDLE cycle
        sel = 1'b0;
        @(posedge clk); #1;
        araddr = 32'h10; arvalid = 1'b1;
        awaddr = 32'h30; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("both_arready", arready_s, 1);
        chk("both_awready", awready_s, 0);
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        chk("both_rvalid", rvalid_s, 1);
        chk("both_rdata", rdata_s, 32'h1234_5678);
        chk("both_awready_in_rresp", awready_s, 0);
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk);
        chk("both_awready_after_read", awready_s, 1);
        chk("both_wready_in_aw_cycle", wready_s, 0);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        chk("both_wready", wready_s, 1);
        @(posedge clk); #1 wvalid = 1'b0;
        do_read(1'b0, 32'h30, 0, 1, 32'h5555_AAAA, "both_readback");

        // Aliasing / bounds
`ifdef AXI_MEM_BOUNDS_EN
        do_write(1'b0, 32'h0000_0004, 32'h1357_9BDF, 4'hF, 1, "oob_pre_wr");
        chk("oob_err_before", err0, 0);
        do_write(1'b0, 32'h0000_4004, 32'h0BAD_F00D, 4'hF, 1, "oob_wr");
        chk("oob_err_after", err0, 1);
        do_read(1'b0, 32'h0000_0004, 0, 1, 32'h1357_9BDF, "oob_word1_rd");
        do_read(1'b0, 32'h0000_4004, 0, 1, 32'hDEAD_BEEF, "oob_rd");
        chk("oob_err_sticky", err0, 1);
        chk("oob_err3_clear", err3, 0);
`else
        do_write(1'b0, 32'h0000_4004, 32'h0BAD_F00D, 4'hF, 1, "alias_wr");
        do_read(1'b0, 32'h0000_0004, 0, 1, 32'h0BAD_F00D, "alias_rd");
`endif

        // Three wait states: latency and held response
        do_write(1'b1, 32'h40, 32'hFEED_FACE, 4'hF, 4, "w3_wr");
        do_read(1'b1, 32'h40, 5, 4, 32'hFEED_FACE, "w3_rd_hold");

        // Reset during W_WAIT drops the write
        sel = 1'b1;
        @(posedge clk); #1;
        awaddr = 32'h40; wdata = 32'h0101_0101; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("rstw_awready", awready_s, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        chk("rstw_wready_in_wait", wready_s, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("rstw_wready_after", wready_s, 0);
        chk("rstw_idle", awready_s, 1);
        repeat (4) @(negedge clk);
        chk("rstw_wready_later", wready_s, 0);
        do_read(1'b1, 32'h40, 0, 4, 32'hFEED_FACE, "rstw_readback");

        // Reset in R_RESP drops the response
        sel = 1'b1;
        @(posedge clk); #1;
        araddr = 32'h40; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("rstr_arready", arready_s, 1);
        @(posedge clk); #1 arvalid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rvalid_s && k < 50);
        chk("rstr_rvalid_before", rvalid_s, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstr_rvalid_after", rvalid_s, 0);
        chk("rstr_rdata_after", rdata_s, 32'h0);
        repeat (3) @(negedge clk);
        chk("rstr_rvalid_later", rvalid_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
